// File: rtl/beam_path_counter.sv
// Beam path counter: streams splitter map rows, propagates per-column beam counts,
// and reports either the number of split events or the total number of timelines.
module beam_path_counter #(
  parameter int WIDTH     = 141,
  parameter int NROWS     = 140,
  parameter int START_COL = 70,
  parameter int CNT_W     = 50,
  parameter int SUM_LANES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             row_valid,
  input  logic [WIDTH-1:0] row_data,
  output logic             row_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             overflow
);

  localparam int NSUM = (WIDTH + SUM_LANES - 1) / SUM_LANES;
  localparam int RW   = $clog2(NROWS + 1);
  localparam int IW   = $clog2(WIDTH + SUM_LANES);
  localparam int PW   = $clog2(WIDTH + 1);
  localparam int TW   = CNT_W + 2;
  localparam int AW   = CNT_W + $clog2(SUM_LANES + 1);
  localparam int SW   = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] MAXV = '1;

  typedef enum logic [2:0] {IDLE, WAIT_ROW, STEP, SUM, DONE} state_t;

  state_t           state, state_nx;
  logic             mode_q;
  logic [WIDTH-1:0] row_q;
  logic [CNT_W-1:0] path     [WIDTH];
  logic [CNT_W-1:0] path_nx  [WIDTH];
  logic [CNT_W-1:0] p_pad    [WIDTH+2];
  logic [CNT_W-1:0] path_ext [2**IW];
  logic [WIDTH+1:0] r_pad;
  logic [RW-1:0]    row_cnt;
  logic [CNT_W-1:0] split_cnt, split_nx, acc, acc_nx;
  logic [IW-1:0]    sum_base;
  logic [TW-1:0]    tsum;
  logic [PW-1:0]    n_split;
  logic [SW-1:0]    split_sum;
  logic [AW-1:0]    lane_sum;
  logic             step_sat, split_sat, sum_sat, last_row, last_sum;

  assign last_row = (row_cnt == RW'(NROWS - 1));
  assign last_sum = (sum_base == IW'((NSUM - 1) * SUM_LANES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = WAIT_ROW;
      WAIT_ROW:   if (row_valid) state_nx = STEP;
      STEP:       if (last_row) state_nx = mode_q ? SUM : DONE;
                  else          state_nx = WAIT_ROW;
      SUM:        if (last_sum) state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    row_ready = (state == WAIT_ROW);
    busy      = (state == WAIT_ROW) || (state == STEP) || (state == SUM);
    done      = (state == DONE);
  end

  // Zero-padded neighbours make edge columns drop beams leaving the grid.
  always_comb begin
    p_pad[0]       = '0;
    p_pad[WIDTH+1] = '0;
    for (int x = 0; x < WIDTH; x++) p_pad[x+1] = path[x];
    r_pad = {1'b0, row_q, 1'b0};
  end

  always_comb begin
    step_sat = 1'b0;
    n_split  = '0;
    tsum     = '0;
    for (int x = 0; x < WIDTH; x++) begin
      tsum = '0;
      if (!r_pad[x+1]) tsum = tsum + TW'(p_pad[x+1]);
      if (r_pad[x])    tsum = tsum + TW'(p_pad[x]);
      if (r_pad[x+2])  tsum = tsum + TW'(p_pad[x+2]);
      if (!mode_q) begin
        path_nx[x] = (tsum != '0) ? CNT_W'(1) : '0;
      end else if (tsum > TW'(MAXV)) begin
        path_nx[x] = MAXV;
        step_sat   = 1'b1;
      end else begin
        path_nx[x] = tsum[CNT_W-1:0];
      end
      if (row_q[x] && (path[x] != '0)) n_split = n_split + PW'(1);
    end
    split_sum = SW'(split_cnt) + SW'(n_split);
    split_sat = (split_sum > SW'(MAXV));
    split_nx  = split_sat ? MAXV : split_sum[CNT_W-1:0];
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) path_ext[i] = path[i];
    for (int i = WIDTH; i < 2**IW; i++) path_ext[i] = '0;
    lane_sum = AW'(acc);
    for (int j = 0; j < SUM_LANES; j++)
      lane_sum = lane_sum + AW'(path_ext[sum_base + IW'(j)]);
    sum_sat = (lane_sum > AW'(MAXV));
    acc_nx  = sum_sat ? MAXV : lane_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      row_q     <= '0;
      row_cnt   <= '0;
      split_cnt <= '0;
      sum_base  <= '0;
      acc       <= '0;
      result    <= '0;
      overflow  <= 1'b0;
      for (int x = 0; x < WIDTH; x++) path[x] <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          mode_q    <= mode;
          row_cnt   <= '0;
          split_cnt <= '0;
          sum_base  <= '0;
          acc       <= '0;
          overflow  <= 1'b0;
          for (int x = 0; x < WIDTH; x++) path[x] <= (x == START_COL) ? CNT_W'(1) : '0;
        end
        WAIT_ROW: if (row_valid) row_q <= row_data;
        STEP: begin
          for (int x = 0; x < WIDTH; x++) path[x] <= path_nx[x];
          row_cnt <= row_cnt + RW'(1);
          if (!mode_q) begin
            split_cnt <= split_nx;
            overflow  <= overflow | split_sat;
            if (last_row) result <= split_nx;
          end else begin
            overflow <= overflow | step_sat;
          end
        end
        SUM: begin
          acc      <= acc_nx;
          sum_base <= sum_base + IW'(SUM_LANES);
          overflow <= overflow | sum_sat;
          if (last_sum) result <= acc_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_beam_path_counter.sv
// Directed bench for beam_path_counter on small 5-column grids, with three
// instances covering centre start, edge start and a narrow saturating counter.
module tb_beam_path_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode, row_valid;
  logic [4:0] row_data;
  logic       start_a, start_b, start_c;
  logic       rdy_a, rdy_b, rdy_c, busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c, ovf_a, ovf_b, ovf_c;
  logic [7:0] res_a, res_b;
  logic [1:0] res_c;
  int         sel;
  int         total = 0;
  int         passed = 0;
  int         cyc;
  int         n_rdy, n_busy, n_done;

  logic       rdy_sel, done_sel, busy_sel, ovf_sel;
  logic [7:0] res_sel;

  always #5 clk = ~clk;

  beam_path_counter #(.WIDTH(5), .NROWS(2), .START_COL(2), .CNT_W(8), .SUM_LANES(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode), .row_valid(row_valid),
    .row_data(row_data), .row_ready(rdy_a), .busy(busy_a), .done(done_a),
    .result(res_a), .overflow(ovf_a));

  beam_path_counter #(.WIDTH(5), .NROWS(2), .START_COL(0), .CNT_W(8), .SUM_LANES(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode), .row_valid(row_valid),
    .row_data(row_data), .row_ready(rdy_b), .busy(busy_b), .done(done_b),
    .result(res_b), .overflow(ovf_b));

  beam_path_counter #(.WIDTH(5), .NROWS(3), .START_COL(2), .CNT_W(2), .SUM_LANES(2)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .mode(mode), .row_valid(row_valid),
    .row_data(row_data), .row_ready(rdy_c), .busy(busy_c), .done(done_c),
    .result(res_c), .overflow(ovf_c));

  always_comb begin
    rdy_sel  = (sel == 0) ? rdy_a  : (sel == 1) ? rdy_b  : rdy_c;
    done_sel = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
    busy_sel = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    ovf_sel  = (sel == 0) ? ovf_a  : (sel == 1) ? ovf_b  : ovf_c;
    res_sel  = (sel == 0) ? res_a  : (sel == 1) ? res_b  : {6'b0, res_c};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic kick(input int s, input logic m);
    sel     = s;
    mode    = m;
    start_a = (s == 0);
    start_b = (s == 1);
    start_c = (s == 2);
  endtask

  // Presents rows in order, advancing only on accepted handshakes.
  task automatic feed(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                      input int max_cyc, output int n);
    int   idx;
    logic acc;
    idx       = 0;
    row_valid = 1'b1;
    row_data  = r0;
    n         = 0;
    do begin
      acc = rdy_sel & row_valid;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      if (acc) begin
        idx++;
        row_data = (idx == 1) ? r1 : (idx == 2) ? r2 : 5'b0;
      end
      n++;
    end while (!done_sel && n < max_cyc);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; row_valid = 1'b0; row_data = '0; sel = 0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy_a), 32'd0);
    chk("rst_busy",  32'(busy_a), 32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    chk("rst_result", 32'(res_a), 32'd0);
    chk("rst_overflow", 32'(ovf_a), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Timelines: rows 00100, 01010 -> counts {1,0,2,0,1}
    kick(0, 1'b1);
    feed(5'b00100, 5'b01010, 5'b00000, 60, cyc);
    chk("m1_latency", 32'(cyc), 32'd8);
    chk("m1_result", 32'(res_sel), 32'd4);
    chk("m1_overflow", 32'(ovf_sel), 32'd0);
    chk("m1_busy_done", 32'(busy_sel), 32'd0);

    kick(0, 1'b0);
    feed(5'b00100, 5'b01010, 5'b00000, 60, cyc);
    chk("m0_latency", 32'(cyc), 32'd5);
    chk("m0_result", 32'(res_sel), 32'd3);
    chk("m0_overflow", 32'(ovf_sel), 32'd0);

    kick(1, 1'b1);
    feed(5'b00001, 5'b00000, 5'b00000, 60, cyc);
    chk("edge_latency", 32'(cyc), 32'd8);
    chk("edge_result", 32'(res_sel), 32'd1);

    // Sum 6 saturates at 3 for a 2-bit counter
    kick(2, 1'b1);
    feed(5'b00100, 5'b01010, 5'b10101, 60, cyc);
    chk("sat_latency", 32'(cyc), 32'd10);
    chk("sat_result", 32'(res_sel), 32'd3);
    chk("sat_overflow", 32'(ovf_sel), 32'd1);

    // 6 split events saturate the split counter at 3
    kick(2, 1'b0);
    feed(5'b00100, 5'b01010, 5'b10101, 60, cyc);
    chk("sat0_latency", 32'(cyc), 32'd7);
    chk("sat0_result", 32'(res_sel), 32'd3);
    chk("sat0_overflow", 32'(ovf_sel), 32'd1);

    // Stall in WAIT_ROW with a stray start pulse in the middle
    kick(0, 1'b1);
    row_valid = 1'b0;
    @(posedge clk); #1;
    start_a = 1'b0;
    n_rdy = 0; n_busy = 0; n_done = 0;
    for (int i = 0; i < 10; i++) begin
      start_a = (i == 5);
      @(posedge clk); #1;
      if (rdy_a) n_rdy++;
      if (busy_a) n_busy++;
      if (done_a) n_done++;
    end
    start_a = 1'b0;
    chk("stall_ready", 32'(n_rdy), 32'd10);
    chk("stall_busy", 32'(n_busy), 32'd10);
    chk("stall_done", 32'(n_done), 32'd0);
    feed(5'b00100, 5'b01010, 5'b00000, 60, cyc);
    chk("stall_latency", 32'(cyc), 32'd7);
    chk("stall_result", 32'(res_sel), 32'd4);

    // Reset in the middle of SUM
    kick(0, 1'b1);
    feed(5'b00100, 5'b01010, 5'b00000, 6, cyc);
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    chk("pre_rst_result", 32'(res_a), 32'd4);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_ready", 32'(rdy_a), 32'd0);
    chk("mid_rst_c_ovf", 32'(ovf_c), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_done", 32'(done_a), 32'd0);
    chk("mid_rst_result", 32'(res_a), 32'd0);
    rst = 1'b0;
    row_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(busy_a), 32'd0);
    kick(0, 1'b1);
    feed(5'b00100, 5'b01010, 5'b00000, 60, cyc);
    chk("rerun_latency", 32'(cyc), 32'd8);
    chk("rerun_result", 32'(res_sel), 32'd4);
    chk("rerun_overflow", 32'(ovf_sel), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
